data_mem_host_ctrl: RTL

Owns the multicore processor's shared data memory and acts as the responder on the processor's data-memory port. It also gives a host (bench or on-chip loader) a load/run/dump command interface. The host streams words in, launches the processor with a one-cycle start pulse, waits for `done`, then streams results back out. Each memory word is `CORE_COUNT` lanes of `MEM_WIDTH` bits, matching the processor data bus.

---
 rtl/data_mem_host_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_host_ctrl.sv
// data_mem_host_ctrl: owns the shared processor data memory and answers the
// processor data port during RUN. A host drives LOAD / RUN / DUMP commands to
// fill memory, launch the processor with a one-cycle start pulse and stream
// results back out.
// Optional feature: define DATA_MEM_RUN_TIMEOUT_EN to enable the RUN watchdog
// (TIMEOUT_CYCLES). Without it, timeout is tied 0 and RUN waits for done.
module data_mem_host_ctrl #(
   parameter int  MEM_WIDTH      = 12,
   parameter int  CORE_COUNT     = 3,
   parameter int  MEM_ADDR       = 11,
   parameter int  TIMEOUT_CYCLES = 65535,
   localparam int DATA_W         = MEM_WIDTH * CORE_COUNT
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [MEM_ADDR-1:0] MemAddr,
   input  logic [DATA_W-1:0]   ProcessorDataOut,
   input  logic                DataMemoryWriteEnable,
   input  logic                done,
   output logic [DATA_W-1:0]   ProcessorDataIn,
   output logic                start,
   input  logic [1:0]          host_cmd,
   input  logic                host_cmd_valid,
   input  logic [MEM_ADDR-1:0] host_base,
   input  logic [MEM_ADDR:0]   host_len,
   input  logic [DATA_W-1:0]   load_data,
   input  logic                load_valid,
   output logic                load_ready,
   output logic [DATA_W-1:0]   dump_data,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic                busy,
   output logic                timeout
);

   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_DUMP = 2'b10;
   localparam logic [1:0] CMD_RUN  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [2**MEM_ADDR];
   logic [MEM_ADDR-1:0] addr;       // next host transfer address (wraps)
   logic [MEM_ADDR:0]   remaining;  // words still to write (LOAD) or read (DUMP)
   logic [DATA_W-1:0]   dbuf [2];   // DUMP output buffer, two entries
   logic                wr_ptr, rd_ptr;
   logic [1:0]          buf_cnt;
   logic                accept, load_fire, issue, pop;

`ifdef DATA_MEM_RUN_TIMEOUT_EN
   localparam int       TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]     run_cnt;
   logic                run_timeout;
`else
   // Keeps the watchdog limit referenced when the watchdog is compiled out.
   logic                unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // State register.
   // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic, transfer handshakes and state-decoded outputs.
   // NOTE: every signal gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      load_fire  = 1'b0;
      issue      = 1'b0;
      pop        = 1'b0;
      start      = 1'b0;
      load_ready = 1'b0;
      busy       = (state != S_IDLE);
      dump_valid = (buf_cnt != 2'd0);
`ifdef DATA_MEM_RUN_TIMEOUT_EN
      run_timeout = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (host_cmd_valid && host_cmd != 2'b00) begin
               accept = 1'b1;
               case (host_cmd)
                  CMD_LOAD: state_nxt = S_LOAD;
                  CMD_DUMP: state_nxt = S_DUMP;
                  default:  state_nxt = S_START;
               endcase
            end
         end
         S_LOAD: begin
            // A zero-length load leaves load_ready low so nothing is written.
            load_ready = (remaining != '0);
            if (remaining == '0) begin
               state_nxt = S_IDLE;
            end else if (load_valid) begin
               load_fire = 1'b1;
               if (remaining == (MEM_ADDR+1)'(1)) state_nxt = S_IDLE;
            end
         end
         S_START: begin
            start     = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (done) begin
               state_nxt = S_IDLE;
            end
`ifdef DATA_MEM_RUN_TIMEOUT_EN
            else if (run_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               run_timeout = 1'b1;
               state_nxt   = S_IDLE;
            end
`endif
         end
         S_DUMP: begin
            pop   = (buf_cnt != 2'd0) && dump_ready;
            // Issue a read whenever the buffer will have room after this edge.
            issue = (remaining != '0) && ((buf_cnt != 2'd2) || pop);
            if (remaining == '0 && (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop)))
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign dump_data = dbuf[rd_ptr];

   // Memory array write port; LOAD and RUN writes never overlap.
   // NOTE: the memory array has no reset; it maps onto RAM and its contents survive reset.
   always_ff @(posedge clock) begin
      if (load_fire)
         mem[addr] <= load_data;
      else if (state == S_RUN && DataMemoryWriteEnable)
         mem[MemAddr] <= ProcessorDataOut;
   end

   // Host transfer counters, DUMP buffer and processor read register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr            <= '0;
         remaining       <= '0;
         dbuf[0]         <= '0;
         dbuf[1]         <= '0;
         wr_ptr          <= 1'b0;
         rd_ptr          <= 1'b0;
         buf_cnt         <= 2'd0;
         ProcessorDataIn <= '0;
      end else begin
         if (accept) begin
            addr      <= host_base;
            remaining <= host_len;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_cnt   <= 2'd0;
         end else begin
            if (load_fire || issue) begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
            end
            if (issue) begin
               dbuf[wr_ptr] <= mem[addr];
               wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (issue && !pop)      buf_cnt <= buf_cnt + 2'd1;
            else if (!issue && pop) buf_cnt <= buf_cnt - 2'd1;
         end
         // Read-first: a same-address write this edge is not yet visible.
         if (state == S_RUN) ProcessorDataIn <= mem[MemAddr];
      end
   end

`ifdef DATA_MEM_RUN_TIMEOUT_EN
   // RUN watchdog: counts RUN cycles and holds a sticky timeout flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == S_START)    run_cnt <= '0;
         else if (state == S_RUN) run_cnt <= run_cnt + 1'b1;
         if (accept && host_cmd == CMD_RUN) timeout <= 1'b0;
         else if (run_timeout)              timeout <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
